// File: rtl/st_buffer_fwd.sv
// Store buffer: holds speculative/committed stores in order, drains committed head, forwards bytes to loads.
// Latency: a pushed store is searchable/drainable the cycle after acceptance; search is combinational.
// Backpressure: push_ready drops when full or flushing; head is held stable while drain_ready is low.
module st_buffer_fwd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int DEPTH      = 4,
    parameter int ROB_TICKET = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ADDR_BITS-1:0]         push_addr,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic [DATA_WIDTH/8-1:0]      push_be,
    input  logic [ROB_TICKET-1:0]        push_ticket,
    input  logic                         commit,
    input  logic                         flush,
    input  logic [ADDR_BITS-1:0]         search_addr,
    input  logic [DATA_WIDTH/8-1:0]      search_be,
    output logic [DATA_WIDTH-1:0]        search_data,
    output logic                         search_hit_full,
    output logic                         search_hit_partial,
    output logic                         drain_valid,
    input  logic                         drain_ready,
    output logic [ADDR_BITS-1:0]         drain_addr,
    output logic [DATA_WIDTH-1:0]        drain_data,
    output logic [DATA_WIDTH/8-1:0]      drain_be,
    output logic [ROB_TICKET-1:0]        drain_ticket,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [ADDR_BITS-1:0] WORD_MASK = ~ADDR_BITS'(BYTES - 1);

    logic [PW-1:0]         head, cptr, tail, cptr_n;
    logic [CW-1:0]         ncommit, ncom_pc, ncommit_n;
    logic [DEPTH-1:0]      vld, vld_n;
    logic                  push_fire, drain_fire, commit_fire;

    logic [ADDR_BITS-1:0]  addr_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [BYTES-1:0]      be_q     [DEPTH];
    logic [ROB_TICKET-1:0] ticket_q [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign push_ready  = !full && !flush;
    assign drain_valid = (ncommit != '0);

    assign push_fire   = push_valid && push_ready;
    assign drain_fire  = drain_valid && drain_ready;
    assign commit_fire = commit && (ncommit < count);

    // Commit is applied before drain and flush, so flush keeps a just-committed entry.
    assign ncom_pc   = ncommit + CW'(commit_fire);
    assign ncommit_n = ncom_pc - CW'(drain_fire);
    assign cptr_n    = commit_fire ? ptr_inc(cptr) : cptr;

    always_comb begin
        logic [PW-1:0] idx;
        vld_n = vld;
        idx   = head;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush && (CW'(k) >= ncom_pc) && (CW'(k) < count))
                vld_n[idx] = 1'b0;
            idx = ptr_inc(idx);
        end
        if (drain_fire)
            vld_n[head] = 1'b0;
        if (push_fire)
            vld_n[tail] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            cptr    <= '0;
            tail    <= '0;
            count   <= '0;
            ncommit <= '0;
            vld     <= '0;
        end else begin
            vld     <= vld_n;
            ncommit <= ncommit_n;
            cptr    <= cptr_n;
            if (drain_fire)
                head <= ptr_inc(head);
            if (flush) begin
                tail  <= cptr_n;
                count <= ncommit_n;
            end else begin
                if (push_fire)
                    tail <= ptr_inc(tail);
                count <= count + CW'(push_fire) - CW'(drain_fire);
            end
        end
    end

    // Payload carries no reset; validity alone decides visibility.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            addr_q[tail]   <= push_addr & WORD_MASK;
            data_q[tail]   <= push_data;
            be_q[tail]     <= push_be;
            ticket_q[tail] <= push_ticket;
        end
    end

    assign drain_addr   = drain_valid ? addr_q[head]   : '0;
    assign drain_data   = drain_valid ? data_q[head]   : '0;
    assign drain_be     = drain_valid ? be_q[head]     : '0;
    assign drain_ticket = drain_valid ? ticket_q[head] : '0;

    // Walk oldest to youngest so younger matches overwrite older lanes.
    always_comb begin
        logic [PW-1:0]    idx;
        logic [BYTES-1:0] cov;
        search_data = '0;
        cov         = '0;
        idx         = head;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[idx] && (addr_q[idx] == (search_addr & WORD_MASK))) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (search_be[b] && be_q[idx][b]) begin
                        search_data[8*b +: 8] = data_q[idx][8*b +: 8];
                        cov[b]                = 1'b1;
                    end
                end
            end
            idx = ptr_inc(idx);
        end
        search_hit_full    = (search_be != '0) && (cov == search_be);
        search_hit_partial = (cov != '0) && !search_hit_full;
    end

endmodule

// File: tb/tb_st_buffer_fwd.sv
// Bench for st_buffer_fwd: directed scenarios plus randomized traffic against a queue-based reference.
module tb_st_buffer_fwd;

    localparam int DW = 32;
    localparam int AB = 32;
    localparam int DEPTH = 4;
    localparam int RT = 3;
    localparam int BY = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          push_valid, push_ready;
    logic [AB-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic [BY-1:0] push_be;
    logic [RT-1:0] push_ticket;
    logic          commit, flush;
    logic [AB-1:0] search_addr;
    logic [BY-1:0] search_be;
    logic [DW-1:0] search_data;
    logic          search_hit_full, search_hit_partial;
    logic          drain_valid, drain_ready;
    logic [AB-1:0] drain_addr;
    logic [DW-1:0] drain_data;
    logic [BY-1:0] drain_be;
    logic [RT-1:0] drain_ticket;
    logic [CW-1:0] count;
    logic          empty, full;

    st_buffer_fwd #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .DEPTH(DEPTH), .ROB_TICKET(RT)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
        .push_data(push_data), .push_be(push_be), .push_ticket(push_ticket),
        .commit(commit), .flush(flush),
        .search_addr(search_addr), .search_be(search_be), .search_data(search_data),
        .search_hit_full(search_hit_full), .search_hit_partial(search_hit_partial),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_be(drain_be), .drain_ticket(drain_ticket),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic [AB-1:0] addr;
        logic [DW-1:0] data;
        logic [BY-1:0] be;
        logic [RT-1:0] tk;
    } ent_t;

    ent_t mq[$];     // oldest first
    int   mnc;       // committed entries at the front of mq
    int   errors = 0;
    int   checks = 0;

    task automatic idle();
        push_valid = 0; push_addr = '0; push_data = '0; push_be = '0; push_ticket = '0;
        commit = 0; flush = 0; drain_ready = 0; search_addr = '0; search_be = '0;
    endtask

    // Advance one clock, updating the reference from the inputs presented this cycle.
    task automatic step();
        bit   pf, df, cf, r;
        ent_t e;
        r  = rst;
        pf = push_valid && (mq.size() < DEPTH) && !flush;
        df = (mnc > 0) && drain_ready;
        cf = commit && (mnc < mq.size());
        e.addr = push_addr & ~32'h3;
        e.data = push_data;
        e.be   = push_be;
        e.tk   = push_ticket;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mnc = 0;
        end else begin
            if (cf) mnc++;
            if (df) begin
                void'(mq.pop_front());
                mnc--;
            end
            if (flush)
                while (mq.size() > mnc) void'(mq.pop_back());
            if (pf) mq.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic push(input logic [AB-1:0] a, input logic [DW-1:0] d, input logic [BY-1:0] be, input logic [RT-1:0] tk);
        push_valid = 1; push_addr = a; push_data = d; push_be = be; push_ticket = tk;
        step();
        push_valid = 0;
    endtask

    task automatic msearch(input logic [AB-1:0] a, input logic [BY-1:0] sb,
                           output logic [DW-1:0] d, output logic hf, output logic hp);
        logic [BY-1:0] cov;
        cov = '0;
        d   = '0;
        foreach (mq[i])
            if (mq[i].addr == (a & ~32'h3))
                for (int b = 0; b < BY; b++)
                    if (sb[b] && mq[i].be[b]) begin
                        d[8*b +: 8] = mq[i].data[8*b +: 8];
                        cov[b] = 1'b1;
                    end
        hf = (sb != '0) && (cov == sb);
        hp = (cov != '0) && !hf;
    endtask

    task automatic test_reset();
        do_reset();
        search_addr = 32'h0; search_be = 4'hF;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (push_ready !== 1'b1 || drain_valid !== 1'b0) begin errors++; $display("FAIL reset_hs push_ready=%b drain_valid=%b exp 1/0", push_ready, drain_valid); end
        checks++; if (search_data !== 32'h0 || search_hit_full !== 1'b0 || search_hit_partial !== 1'b0) begin
            errors++; $display("FAIL reset_search data=%h full=%b part=%b exp 0/0/0", search_data, search_hit_full, search_hit_partial); end
        search_be = '0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'h1000 + 32'(i), 4'hF, 3'(i));
        checks++; if (full !== 1'b1 || push_ready !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL full_state full=%b push_ready=%b count=%0d exp 1/0/4", full, push_ready, count); end
        push(32'h110, 32'hDEAD, 4'hF, 3'd4);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignore count=%0d exp=4", count); end
    endtask

    task automatic test_merge();
        do_reset();
        push(32'h200, 32'h11223344, 4'hF, 3'd1);
        push(32'h200, 32'hAABBCCDD, 4'b0011, 3'd2);
        search_addr = 32'h200; search_be = 4'hF;
        #1;
        checks++; if (search_data !== 32'h1122CCDD || search_hit_full !== 1'b1) begin
            errors++; $display("FAIL merge_youngest data=%h full=%b exp 1122ccdd/1", search_data, search_hit_full); end
        commit = 1; step(); commit = 0;
        drain_ready = 1; step(); drain_ready = 0;
        search_be = 4'b0100;
        #1;
        checks++; if (count !== 3'd1 || search_hit_full !== 1'b0 || search_hit_partial !== 1'b0) begin
            errors++; $display("FAIL merge_miss count=%0d full=%b part=%b exp 1/0/0", count, search_hit_full, search_hit_partial); end
        search_be = '0;
    endtask

    task automatic test_partial();
        do_reset();
        push(32'h300, 32'hDEADBEEF, 4'b0011, 3'd3);
        search_addr = 32'h302; search_be = 4'hF;
        #1;
        checks++; if (search_hit_partial !== 1'b1 || search_hit_full !== 1'b0 || search_data !== 32'h0000BEEF) begin
            errors++; $display("FAIL partial part=%b full=%b data=%h exp 1/0/0000beef", search_hit_partial, search_hit_full, search_data); end
        search_be = '0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(4*i), 32'h4000 + 32'(i), 4'hF, 3'(i));
        commit = 1; step(); commit = 0;
        flush = 1; push_valid = 1; push_addr = 32'h40C; push_be = 4'hF; step(); flush = 0; push_valid = 0;
        checks++; if (count !== 3'd1 || drain_valid !== 1'b1 || drain_addr !== 32'h400) begin
            errors++; $display("FAIL flush_keep count=%0d dv=%b addr=%h exp 1/1/400", count, drain_valid, drain_addr); end
        for (int i = 1; i < 4; i++) begin
            search_addr = 32'h400 + 32'(4*i); search_be = 4'hF;
            #1;
            checks++; if (search_hit_full !== 1'b0 || search_hit_partial !== 1'b0) begin
                errors++; $display("FAIL flush_miss addr=%h full=%b part=%b exp 0/0", search_addr, search_hit_full, search_hit_partial); end
        end
        search_be = '0;
    endtask

    task automatic test_commit_flush();
        do_reset();
        push(32'h500, 32'h5050, 4'hF, 3'd0);
        push(32'h504, 32'h5454, 4'hF, 3'd1);
        commit = 1; step();
        flush = 1; step(); commit = 0; flush = 0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL cf_count count=%0d exp=2", count); end
        drain_ready = 1;
        checks++; if (drain_valid !== 1'b1 || drain_addr !== 32'h500) begin errors++; $display("FAIL cf_drain0 dv=%b addr=%h exp 1/500", drain_valid, drain_addr); end
        step();
        checks++; if (drain_valid !== 1'b1 || drain_addr !== 32'h504) begin errors++; $display("FAIL cf_drain1 dv=%b addr=%h exp 1/504", drain_valid, drain_addr); end
        step();
        drain_ready = 0;
        checks++; if (empty !== 1'b1 || drain_valid !== 1'b0) begin errors++; $display("FAIL cf_empty empty=%b dv=%b exp 1/0", empty, drain_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        push(32'h603, 32'hCAFEF00D, 4'b1010, 3'd5);
        commit = 1; step(); commit = 0;
        drain_ready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (drain_valid !== 1'b1 || drain_addr !== 32'h600 || drain_data !== 32'hCAFEF00D ||
                drain_be !== 4'b1010 || drain_ticket !== 3'd5) begin
                errors++; $display("FAIL stall_hold cyc=%0d dv=%b addr=%h data=%h be=%b tk=%0d exp 1/600/cafef00d/1010/5",
                                   i, drain_valid, drain_addr, drain_data, drain_be, drain_ticket); end
            step();
        end
        drain_ready = 1; step(); drain_ready = 0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stall_release count=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(32'h700, 32'h0, 4'hF, 3'd0);
        push(32'h704, 32'h1, 4'hF, 3'd1);
        commit = 1; step(); step();
        for (int j = 0; j < 2*DEPTH; j++) begin
            push_valid = 1; push_addr = 32'h708 + 32'(4*j); push_data = 32'(j + 2); push_be = 4'hF;
            drain_ready = 1;
            #1;
            checks++; if (drain_valid !== 1'b1 || drain_addr !== 32'h700 + 32'(4*j)) begin
                errors++; $display("FAIL b2b_head j=%0d dv=%b addr=%h exp 1/%h", j, drain_valid, drain_addr, 32'h700 + 32'(4*j)); end
            step();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count j=%0d count=%0d exp=2", j, count); end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(32'h800, 32'h8, 4'hF, 3'd0);
        commit = 1; push(32'h804, 32'h9, 4'hF, 3'd1); commit = 0;
        rst = 1; push_valid = 1; drain_ready = 1; step(); rst = 0; idle();
        checks++; if (count !== 3'd0 || drain_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset count=%0d dv=%b exp 0/0", count, drain_valid); end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          ehf, ehp;
        ent_t          h;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            push_valid  = ($urandom_range(0, 9) < 6);
            push_addr   = 32'h40 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            push_data   = $urandom;
            push_be     = 4'($urandom);
            push_ticket = 3'($urandom);
            commit      = ($urandom_range(0, 9) < 4);
            flush       = ($urandom_range(0, 15) == 0);
            drain_ready = ($urandom_range(0, 1) == 1);
            search_addr = 32'h40 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            search_be   = 4'($urandom);
            #1;
            msearch(search_addr, search_be, ed, ehf, ehp);
            if (mnc > 0) h = mq[0];
            else begin h.addr = '0; h.data = '0; h.be = '0; h.tk = '0; end
            checks++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_occ cyc=%0d count=%0d empty=%b full=%b exp count=%0d", c, count, empty, full, mq.size()); end
            checks++; if (push_ready !== ((mq.size() < DEPTH) && !flush) || drain_valid !== (mnc > 0)) begin
                errors++; $display("FAIL rnd_hs cyc=%0d push_ready=%b drain_valid=%b exp size=%0d ncommit=%0d", c, push_ready, drain_valid, mq.size(), mnc); end
            checks++; if (drain_addr !== h.addr || drain_data !== h.data || drain_be !== h.be || drain_ticket !== h.tk) begin
                errors++; $display("FAIL rnd_drain cyc=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", c, drain_addr, drain_data, drain_be, drain_ticket, h.addr, h.data, h.be, h.tk); end
            checks++; if (search_data !== ed || search_hit_full !== ehf || search_hit_partial !== ehp) begin
                errors++; $display("FAIL rnd_search cyc=%0d got=%h/%b/%b exp=%h/%b/%b", c, search_data, search_hit_full, search_hit_partial, ed, ehf, ehp); end
            step();
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        mnc = 0;
        test_reset();
        test_full();
        test_merge();
        test_partial();
        test_flush();
        test_commit_flush();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
